// File: rtl/brmask_ctrl.sv
// Branch-tag allocator and mispredict recovery sequencer for decode.
// Hands out one-hot tags, tracks per-tag dependency masks, and squashes younger tags on a mispredict.
module brmask_ctrl #(
   parameter int WIDTH_BRM   = 3,
   parameter int RECOVER_CYC = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   input  logic                 i_is_br,
   output logic                 o_ready,
   output logic                 o_en_j,
   output logic [WIDTH_BRM-1:0] o_brtag,
   output logic [WIDTH_BRM-1:0] o_brmask,
   input  logic                 i_res_valid,
   input  logic [WIDTH_BRM-1:0] i_res_tag,
   input  logic                 i_mispred,
   output logic                 o_kill,
   output logic [WIDTH_BRM-1:0] o_kill_mask,
   output logic [WIDTH_BRM-1:0] o_free
);

   localparam int CNT_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

   typedef enum logic {RUN, RECOVER} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_nxt;

   logic [WIDTH_BRM-1:0] inflight;
   logic [WIDTH_BRM-1:0] dep [WIDTH_BRM];

   logic                 res_hit;
   logic                 correct;
   logic                 mispred_now;
   logic [WIDTH_BRM-1:0] resolved;
   logic [WIDTH_BRM-1:0] eff;
   logic [WIDTH_BRM-1:0] kill;
   logic [WIDTH_BRM-1:0] free;
   logic [WIDTH_BRM-1:0] chosen;
   logic                 full;
   logic                 ready;
   logic                 alloc;
   logic [WIDTH_BRM-1:0] alloc_tag;

   // Resolution decode: a resolve of a tag that is not in flight is ignored entirely.
   always_comb begin
      res_hit     = i_res_valid && ((i_res_tag & inflight) != '0);
      correct     = res_hit && !i_mispred;
      mispred_now = res_hit && i_mispred;
      resolved    = correct ? i_res_tag : '0;
      eff         = inflight & ~resolved;
      full        = &inflight;
      // Lowest free bit; a tag freed this cycle is still marked busy here.
      free        = ~inflight;
      chosen      = free & (~free + WIDTH_BRM'(1));
   end

   // Squash set: the mispredicted tag plus every in-flight tag that depends on it.
   always_comb begin
      kill = '0;
      if (mispred_now) begin
         kill = i_res_tag;
         for (int u = 0; u < WIDTH_BRM; u++) begin
            if ((dep[u] & i_res_tag) != '0) kill[u] = 1'b1;
         end
         kill = kill & inflight;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         RUN: begin
            if (mispred_now) begin
               state_nxt = RECOVER;
               cnt_nxt   = CNT_W'(RECOVER_CYC - 1);
            end
         end
         RECOVER: begin
            if (mispred_now) begin
               cnt_nxt = CNT_W'(RECOVER_CYC - 1);
            end else if (cnt == '0) begin
               state_nxt = RUN;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = RUN;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      ready     = (state == RUN) && !(i_valid && i_is_br && full) && !mispred_now;
      alloc     = i_valid && i_is_br && ready;
      alloc_tag = alloc ? chosen : '0;
   end

   assign o_ready     = ready;
   assign o_en_j      = alloc;
   assign o_brtag     = alloc_tag;
   assign o_brmask    = (ready && i_valid) ? eff : '0;
   assign o_kill      = mispred_now;
   assign o_kill_mask = kill;
   assign o_free      = correct ? i_res_tag : kill;

   // Tag state update: retire resolved/killed tags, then record the new allocation.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= '0;
         for (int u = 0; u < WIDTH_BRM; u++) dep[u] <= '0;
      end else begin
         inflight <= (inflight & ~resolved & ~kill) | alloc_tag;
         for (int u = 0; u < WIDTH_BRM; u++) begin
            if (alloc_tag[u]) dep[u] <= eff;
            else              dep[u] <= dep[u] & ~resolved & ~kill;
         end
      end
   end

endmodule

// File: tb/tb_brmask_ctrl.sv
// Bench for brmask_ctrl: directed scenarios plus random traffic against an age-ordered tag queue model.
module tb_brmask_ctrl;
   localparam int W  = 3;
   localparam int RC = 2;
   localparam int OW = 3 + 4 * W;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_valid, i_is_br, i_res_valid, i_mispred;
   logic [W-1:0] i_res_tag;
   logic         o_ready, o_en_j, o_kill;
   logic [W-1:0] o_brtag, o_brmask, o_kill_mask, o_free;

   brmask_ctrl #(.WIDTH_BRM(W), .RECOVER_CYC(RC)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_is_br(i_is_br),
      .o_ready(o_ready), .o_en_j(o_en_j), .o_brtag(o_brtag), .o_brmask(o_brmask),
      .i_res_valid(i_res_valid), .i_res_tag(i_res_tag), .i_mispred(i_mispred),
      .o_kill(o_kill), .o_kill_mask(o_kill_mask), .o_free(o_free)
   );

   always #5 clk = ~clk;

   wire [OW-1:0] obs = {o_ready, o_en_j, o_brtag, o_brmask, o_kill, o_kill_mask, o_free};
   localparam logic [OW-1:0] RST_VEC = {1'b1, {(OW-1){1'b0}}};

   int n_cmp  = 0;
   int n_fail = 0;
   logic [OW-1:0] exp;

   // Reference model: tags in flight listed oldest first; dependants of a tag are the ones after it.
   int q[$];
   int hold;
   logic m_mis, m_cor, m_en;
   int   m_ti, m_tgi, m_pos;

   function automatic logic [W-1:0] m_infl();
      logic [W-1:0] m = '0;
      foreach (q[i]) m[q[i]] = 1'b1;
      return m;
   endfunction

   task automatic model_eval(output logic [OW-1:0] e);
      logic [W-1:0] infl, eff, tg, bm, km, fr;
      logic rdy;
      infl = m_infl();
      m_ti = -1;
      if (i_res_valid)
         for (int i = 0; i < W; i++) if (i_res_tag == W'(1 << i) && infl[i]) m_ti = i;
      m_mis = (m_ti >= 0) && i_mispred;
      m_cor = (m_ti >= 0) && !i_mispred;
      eff = infl;
      if (m_cor) eff[m_ti] = 1'b0;
      rdy  = (hold == 0) && !m_mis && !(i_valid && i_is_br && q.size() == W);
      m_en = i_valid && i_is_br && rdy;
      tg = '0;
      m_tgi = -1;
      if (m_en)
         for (int i = W - 1; i >= 0; i--) if (!infl[i]) m_tgi = i;
      if (m_tgi >= 0) tg[m_tgi] = 1'b1;
      bm = (rdy && i_valid) ? eff : '0;
      km = '0;
      m_pos = -1;
      if (m_mis)
         foreach (q[i]) begin
            if (q[i] == m_ti) m_pos = i;
            if (m_pos >= 0) km[q[i]] = 1'b1;
         end
      fr = m_cor ? i_res_tag : km;
      e = {rdy, m_en, tg, bm, m_mis, km, fr};
   endtask

   task automatic model_commit();
      if (rst) begin
         q.delete();
         hold = 0;
         return;
      end
      if (m_cor)
         foreach (q[i]) if (q[i] == m_ti) begin q.delete(i); break; end
      if (m_mis) begin
         while (q.size() > m_pos) void'(q.pop_back());
         hold = RC;
      end else if (hold > 0) begin
         hold--;
      end
      if (m_en) q.push_back(m_tgi);
   endtask

   task automatic drive(input logic v, input logic b, input logic rv,
                        input logic [W-1:0] rt, input logic mp);
      i_valid = v; i_is_br = b; i_res_valid = rv; i_res_tag = rt; i_mispred = mp;
   endtask

   task automatic settle();
      @(negedge clk);
      model_eval(exp);
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, 0, '0, 0);
      settle(); advance();
      settle(); advance();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      settle();
      n_cmp++;
      if (obs !== RST_VEC) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, RST_VEC); end
      n_cmp++;
      if (obs !== exp) begin n_fail++; $display("FAIL reset_model: got %b want %b", obs, exp); end
      advance();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] t;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, '0, 0);
         settle();
         t = W'(1 << i);
         n_cmp++;
         if (o_brtag !== t || o_brmask !== t - W'(1) || o_en_j !== 1'b1) begin
            n_fail++; $display("FAIL b2b_alloc[%0d]: got tag %b mask %b en %b want tag %b mask %b en 1",
                               i, o_brtag, o_brmask, o_en_j, t, t - W'(1));
         end
         n_cmp++;
         if (obs !== exp) begin n_fail++; $display("FAIL b2b_model[%0d]: got %b want %b", i, obs, exp); end
         advance();
      end
      settle();
      n_cmp++;
      if (o_ready !== 1'b0 || o_en_j !== 1'b0) begin
         n_fail++; $display("FAIL full_stall: got ready %b en %b want ready 0 en 0", o_ready, o_en_j);
      end
      drive(1, 0, 0, '0, 0);
      settle();
      n_cmp++;
      if (o_ready !== 1'b1 || o_brmask !== 3'b111) begin
         n_fail++; $display("FAIL full_nonbranch: got ready %b mask %b want ready 1 mask 111", o_ready, o_brmask);
      end
      advance();
   endtask

   task automatic test_full_resolve();
      drive(1, 1, 1, 3'b010, 0);
      settle();
      n_cmp++;
      if (o_free !== 3'b010 || o_ready !== 1'b0 || o_kill !== 1'b0) begin
         n_fail++; $display("FAIL full_resolve: got free %b ready %b kill %b want free 010 ready 0 kill 0",
                            o_free, o_ready, o_kill);
      end
      n_cmp++;
      if (obs !== exp) begin n_fail++; $display("FAIL full_resolve_model: got %b want %b", obs, exp); end
      advance();
      drive(1, 1, 0, '0, 0);
      settle();
      n_cmp++;
      if (o_brtag !== 3'b010 || o_brmask !== 3'b101) begin
         n_fail++; $display("FAIL reuse_tag: got tag %b mask %b want tag 010 mask 101", o_brtag, o_brmask);
      end
      advance();
   endtask

   task automatic alloc_n(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1, 1, 0, '0, 0);
         settle(); advance();
      end
   endtask

   task automatic test_mispredict();
      do_reset();
      alloc_n(3);
      drive(1, 1, 1, 3'b010, 1);
      settle();
      n_cmp++;
      if (o_kill !== 1'b1 || o_kill_mask !== 3'b110 || o_free !== 3'b110 || o_ready !== 1'b0) begin
         n_fail++; $display("FAIL mispred_kill: got kill %b kmask %b free %b ready %b want 1 110 110 0",
                            o_kill, o_kill_mask, o_free, o_ready);
      end
      advance();
      for (int i = 0; i < RC; i++) begin
         drive(1, 1, 0, '0, 0);
         settle();
         n_cmp++;
         if (o_ready !== 1'b0 || o_en_j !== 1'b0 || o_kill !== 1'b0) begin
            n_fail++; $display("FAIL recover_hold[%0d]: got ready %b en %b kill %b want 0 0 0",
                               i, o_ready, o_en_j, o_kill);
         end
         advance();
      end
      settle();
      n_cmp++;
      if (o_ready !== 1'b1 || o_brtag !== 3'b010 || o_brmask !== 3'b001) begin
         n_fail++; $display("FAIL after_recover: got ready %b tag %b mask %b want 1 010 001",
                            o_ready, o_brtag, o_brmask);
      end
      advance();
   endtask

   task automatic test_alloc_and_resolve();
      do_reset();
      alloc_n(1);
      drive(1, 1, 1, 3'b001, 0);
      settle();
      n_cmp++;
      if (o_brtag !== 3'b010 || o_brmask !== 3'b000 || o_free !== 3'b001) begin
         n_fail++; $display("FAIL alloc_resolve: got tag %b mask %b free %b want 010 000 001",
                            o_brtag, o_brmask, o_free);
      end
      advance();
      drive(1, 0, 0, '0, 0);
      settle();
      n_cmp++;
      if (o_brmask !== 3'b010) begin
         n_fail++; $display("FAIL alloc_resolve_next: got mask %b want 010", o_brmask);
      end
      advance();
   endtask

   task automatic test_resolve_in_recover();
      do_reset();
      alloc_n(2);
      drive(0, 0, 1, 3'b010, 1);
      settle(); advance();
      drive(1, 1, 1, 3'b001, 0);
      settle();
      n_cmp++;
      if (o_free !== 3'b001 || o_kill !== 1'b0 || o_ready !== 1'b0) begin
         n_fail++; $display("FAIL recover_resolve: got free %b kill %b ready %b want 001 0 0",
                            o_free, o_kill, o_ready);
      end
      advance();
      drive(1, 1, 0, '0, 0);
      settle();
      n_cmp++;
      if (o_ready !== 1'b0) begin n_fail++; $display("FAIL recover_len: got ready %b want 0", o_ready); end
      advance();
      settle();
      n_cmp++;
      if (o_ready !== 1'b1 || o_brtag !== 3'b001 || o_brmask !== 3'b000) begin
         n_fail++; $display("FAIL recover_exit: got ready %b tag %b mask %b want 1 001 000",
                            o_ready, o_brtag, o_brmask);
      end
      advance();
   endtask

   task automatic test_reset_in_recover();
      do_reset();
      alloc_n(3);
      drive(0, 0, 1, 3'b100, 1);
      settle(); advance();
      rst = 1'b1;
      drive(0, 0, 0, '0, 0);
      settle(); advance();
      rst = 1'b0;
      settle();
      n_cmp++;
      if (obs !== RST_VEC) begin n_fail++; $display("FAIL rst_recover: got %b want %b", obs, RST_VEC); end
      advance();
      drive(1, 1, 0, '0, 0);
      settle();
      n_cmp++;
      if (o_brtag !== 3'b001 || o_brmask !== 3'b000) begin
         n_fail++; $display("FAIL rst_recover_alloc: got tag %b mask %b want 001 000", o_brtag, o_brmask);
      end
      advance();
   endtask

   task automatic test_random();
      logic [W-1:0] rt;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         rt  = ($urandom_range(0, 5) == 0) ? '0 : W'(1 << $urandom_range(0, W - 1));
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 2) == 0, rt, $urandom_range(0, 3) == 0);
         settle();
         if (!rst) begin
            n_cmp++;
            if (obs !== exp) begin n_fail++; $display("FAIL random[%0d]: got %b want %b", c, obs, exp); end
         end
         advance();
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      hold = 0;
      drive(0, 0, 0, '0, 0);
      test_reset();
      test_back_to_back();
      test_full_resolve();
      test_mispredict();
      test_alloc_and_resolve();
      test_resolve_in_recover();
      test_reset_in_recover();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
